// File: rtl/instr_fetch_pkg.sv
// Shared constants and the fetch buffer entry type
// for the instruction fetch stage.
package instr_fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO of {pc, instr} entries with
// flush; flush wins over a same-cycle push or pop.
module instr_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  fetch_entry_t i_entry,
    input  logic         i_pop,
    input  logic         i_flush,
    output fetch_entry_t o_head,
    output logic [CW-1:0] o_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop  = i_pop && !i_flush && (r_count != '0);
    assign w_push = i_push && !i_flush &&
                    ((r_count != CW'(DEPTH)) || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= nxt(r_wptr);
            if (w_pop)  r_rptr <= nxt(r_rptr);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch stage: credit-limited in-order imem requests,
// response buffering and redirect with stale-response drop.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int DW = CW + 1;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_live_cnt;
    logic [DW-1:0]   r_drop_cnt;

    logic [CW-1:0]   w_fifo_cnt;
    logic [DW-1:0]   w_credit;
    logic [DW-1:0]   w_drop_sum;
    logic [XLEN-1:0] w_redir_pc;
    logic            w_fire;
    logic            w_resp;
    logic            w_drop;
    logic            w_pop;
    fetch_entry_t    w_entry;
    fetch_entry_t    w_head;
    logic            w_unused;

    assign w_unused   = ^redirect_pc[1:0];
    assign w_redir_pc = {redirect_pc[31:2], 2'b00};

    assign w_credit = DW'(r_live_cnt) + DW'(w_fifo_cnt);
    assign imem_req = (w_credit < DW'(BUF_DEPTH)) && !redirect_valid;
    assign imem_addr = r_pc;

    assign w_fire = imem_req && imem_gnt;
    // An rvalid with nothing outstanding is a protocol error and is ignored
    assign w_resp = imem_rvalid && (r_drop_cnt == '0) &&
                    (r_live_cnt != '0);
    assign w_drop = imem_rvalid && (r_drop_cnt != '0);
    assign w_drop_sum = r_drop_cnt + DW'(r_live_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_live_cnt <= '0;
            r_drop_cnt <= '0;
        end else if (redirect_valid) begin
            r_pc       <= w_redir_pc;
            r_resp_pc  <= w_redir_pc;
            r_live_cnt <= '0;
            r_drop_cnt <= (imem_rvalid && (w_drop_sum != '0)) ?
                          w_drop_sum - 1'b1 : w_drop_sum;
        end else begin
            if (w_fire) r_pc <= r_pc + XLEN'(INSTR_BYTES);
            if (w_resp) r_resp_pc <= r_resp_pc + XLEN'(INSTR_BYTES);
            r_live_cnt <= r_live_cnt + CW'(w_fire) - CW'(w_resp);
            if (w_drop) r_drop_cnt <= r_drop_cnt - 1'b1;
        end
    end

    assign w_entry = '{pc: r_resp_pc, instr: imem_rdata};
    assign w_pop   = instr_valid && instr_ready;

    instr_fifo #(
        .DEPTH (BUF_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_resp),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_head  (w_head),
        .o_count (w_fifo_cnt)
    );

    assign instr_valid = (w_fifo_cnt != '0);
    assign instr       = instr_valid ? w_head.instr : NOP_INSTR;
    assign instr_pc    = instr_valid ? w_head.pc : '0;

    a_rvalid_outstanding: assert property (
        @(posedge clk) disable iff (!rst_n)
        imem_rvalid |-> ((r_live_cnt != '0) || (r_drop_cnt != '0))
    );

endmodule
